// File: rtl/decode_pipe_if.sv
// Bundle of every signal between the decode stage and its neighbours:
// IF/ID upstream, execute downstream, and the writeback/load-hazard
// sidebands coming back from later stages.
interface decode_pipe_if #(
  parameter int DATA_W = 16
);
  // upstream handshake and instruction payload
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       instruction;
  logic [DATA_W-1:0] pc_in;
  logic              zero_ext;
  logic [1:0]        reg_dst;
  // writeback port into the register file
  logic              wb_en;
  logic [2:0]        wb_sel;
  logic [DATA_W-1:0] wb_data;
  // load-use hazard sideband and squash
  logic              ex_load;
  logic [2:0]        ex_rd;
  logic              flush;
  // downstream handshake and ID/EX payload
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       out_instr;
  logic [DATA_W-1:0] out_pc;
  logic [DATA_W-1:0] read_data1;
  logic [DATA_W-1:0] read_data2;
  logic [DATA_W-1:0] imm5_ext;
  logic [DATA_W-1:0] imm8_ext;
  logic [DATA_W-1:0] imm11_ext;
  logic [2:0]        write_reg;
  logic              stall;

  // environment side: drives instructions, writebacks and the downstream ready
  modport master (
    output in_valid, instruction, pc_in, zero_ext, reg_dst,
    output wb_en, wb_sel, wb_data, ex_load, ex_rd, flush, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, read_data1, read_data2,
    input  imm5_ext, imm8_ext, imm11_ext, write_reg, stall
  );

  // decode stage side
  modport slave (
    input  in_valid, instruction, pc_in, zero_ext, reg_dst,
    input  wb_en, wb_sel, wb_data, ex_load, ex_rd, flush, out_ready,
    output in_ready, out_valid, out_instr, out_pc, read_data1, read_data2,
    output imm5_ext, imm8_ext, imm11_ext, write_reg, stall
  );
endinterface

// File: rtl/decode_pipe.sv
// Pipelined decode stage: 8-entry register file, immediate extension,
// destination select, load-use stall, and a valid/ready ID/EX register.
module decode_pipe #(
  parameter int DATA_W      = 16,
  parameter bit BYPASS      = 1'b1,
  parameter bit LOAD_HAZARD = 1'b1
) (
  input logic          clk,
  input logic          rst,
  decode_pipe_if.slave bus
);

  typedef struct packed {
    logic [15:0]       instr;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] imm5;
    logic [DATA_W-1:0] imm8;
    logic [DATA_W-1:0] imm11;
    logic [2:0]        wreg;
  } idex_t;

  logic [DATA_W-1:0] regs_q [8];
  logic [DATA_W-1:0] regs_d [8];
  idex_t             idex_q, idex_d, idex_new;
  logic              valid_q, valid_d;
  logic [2:0]        rs_sel, rt_sel;
  logic              hazard, advance;

  assign rs_sel = bus.instruction[10:8];
  assign rt_sel = bus.instruction[7:5];

  // Load-use check looks at both source fields whatever the format.
  assign hazard  = LOAD_HAZARD && bus.in_valid && bus.ex_load &&
                   ((bus.ex_rd == rs_sel) || (bus.ex_rd == rt_sel));
  assign advance = bus.out_ready || !valid_q;

  assign bus.stall    = hazard;
  assign bus.in_ready = bus.flush || (advance && !hazard);

  assign bus.out_valid  = valid_q;
  assign bus.out_instr  = idex_q.instr;
  assign bus.out_pc     = idex_q.pc;
  assign bus.read_data1 = idex_q.rd1;
  assign bus.read_data2 = idex_q.rd2;
  assign bus.imm5_ext   = idex_q.imm5;
  assign bus.imm8_ext   = idex_q.imm8;
  assign bus.imm11_ext  = idex_q.imm11;
  assign bus.write_reg  = idex_q.wreg;

  // Register file next state: a single write port from writeback.
  always_comb begin
    regs_d = regs_q;
    if (bus.wb_en) regs_d[bus.wb_sel] = bus.wb_data;
  end

  // Decode the incoming instruction into the ID/EX payload it would load.
  always_comb begin
    idex_new       = '0;
    idex_new.instr = bus.instruction;
    idex_new.pc    = bus.pc_in;
    idex_new.rd1   = regs_q[rs_sel];
    idex_new.rd2   = regs_q[rt_sel];
    if (BYPASS && bus.wb_en && (bus.wb_sel == rs_sel)) idex_new.rd1 = bus.wb_data;
    if (BYPASS && bus.wb_en && (bus.wb_sel == rt_sel)) idex_new.rd2 = bus.wb_data;
    idex_new.imm5  = bus.zero_ext ? {{(DATA_W-5){1'b0}}, bus.instruction[4:0]}
                                  : {{(DATA_W-5){bus.instruction[4]}}, bus.instruction[4:0]};
    idex_new.imm8  = bus.zero_ext ? {{(DATA_W-8){1'b0}}, bus.instruction[7:0]}
                                  : {{(DATA_W-8){bus.instruction[7]}}, bus.instruction[7:0]};
    idex_new.imm11 = {{(DATA_W-11){bus.instruction[10]}}, bus.instruction[10:0]};
    unique case (bus.reg_dst)
      2'b00:   idex_new.wreg = bus.instruction[7:5];
      2'b01:   idex_new.wreg = bus.instruction[10:8];
      2'b10:   idex_new.wreg = bus.instruction[4:2];
      default: idex_new.wreg = 3'd7;
    endcase
  end

  // ID/EX update in priority order: flush, bubble, load, drain, hold.
  always_comb begin
    valid_d = valid_q;
    idex_d  = idex_q;
    if (bus.flush) begin
      valid_d = 1'b0;
    end else if (advance && hazard) begin
      valid_d = 1'b0;
    end else if (advance && bus.in_valid) begin
      valid_d = 1'b1;
      idex_d  = idex_new;
    end else if (advance) begin
      valid_d = 1'b0;
    end
  end

  // Register file state.
  // NOTE: the register file is reset explicitly because software relies on
  // every register reading 0 after reset; this keeps it in flops, not RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // ID/EX pipeline register; payload reset so outputs never carry X.
  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      idex_q  <= '0;
    end else begin
      valid_q <= valid_d;
      idex_q  <= idex_d;
    end
  end

endmodule
